// File: rtl/shader_pkg.sv
// Shared types and helpers for the face shading slice.
package shader_pkg;

    // Default fixed-point format for unit light intensity (1.0 = ONE).
    localparam int unsigned DEF_NORM_FRAC = 14;
    localparam int unsigned ONE           = 1 << DEF_NORM_FRAC;

    // RGB565 pixel colour.
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Clamp a signed fixed-point intensity to [0, 1.0] for the given fraction width.
    function automatic logic [31:0] clamp_unit(input logic signed [31:0] intensity,
                                               input int frac);
        logic signed [31:0] one_s;
        logic [31:0]        result;
        one_s = 32'sd1 <<< frac;
        if (intensity < 0)
            result = '0;
        else if (intensity > one_s)
            result = one_s;
        else
            result = intensity;
        return result;
    endfunction

endpackage

// File: rtl/shade_fifo.sv
// Generic synchronous show-ahead FIFO; extra pointer MSB separates full from empty.
module shade_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    // Head is forced to zero while empty so stale entries never show.
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)
                level <= level + 1'b1;
            else if (!do_wr && do_rd)
                level <= level - 1'b1;
        end
    end

    // Storage array; no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/face_shade_stage.sv
// Back-face cull, intensity shading of RGB565 colour, and queued delivery downstream.
module face_shade_stage
    import shader_pkg::*;
#(
    parameter int                    NORM_WIDTH  = 16,
    parameter int                    NORM_FRAC   = 14,
    parameter int                    ID_WIDTH    = 12,
    parameter logic [NORM_WIDTH-1:0] AMBIENT     = 16'h0CCD,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    input  logic                          front_facing_in,
    input  logic signed [NORM_WIDTH-1:0]  intensity_in,
    input  logic [15:0]                   color_in,
    input  logic [ID_WIDTH-1:0]           tri_id_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [15:0]                   color_out,
    output logic [ID_WIDTH-1:0]           tri_id_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out,
    output logic [COUNT_WIDTH-1:0]        cull_count_out,
    output logic [COUNT_WIDTH-1:0]        shade_count_out
);

    localparam int          SCALE_W = NORM_FRAC + 1;
    localparam logic [31:0] UNIT    = 32'd1 << NORM_FRAC;
    localparam int          PAY_W   = ID_WIDTH + 16;

    // S1 registers
    logic                s1_valid;
    logic [SCALE_W-1:0]  s1_scale;
    rgb565_t             s1_color;
    logic [ID_WIDTH-1:0] s1_id;
    // S2 registers
    logic                s2_valid;
    logic [5+SCALE_W-1:0] s2_r;
    logic [6+SCALE_W-1:0] s2_g;
    logic [5+SCALE_W-1:0] s2_b;
    logic [ID_WIDTH-1:0] s2_id;
    // S3 registers
    logic                s3_valid;
    rgb565_t             s3_color;
    logic [ID_WIDTH-1:0] s3_id;

    logic [31:0]         clamped;
    logic [31:0]         lit;
    logic [31:0]         scale;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_rd;
    logic                fifo_accept;
    logic [PAY_W-1:0]    fifo_head;

    // Clamp intensity, add ambient and cap the resulting scale at 1.0.
    always_comb begin
        clamped = clamp_unit(32'(intensity_in), NORM_FRAC);
        lit     = clamped + 32'(AMBIENT);
        scale   = (lit > UNIT) ? UNIT : lit;
    end

    // S1: cull back faces and register the scale factor.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid       <= 1'b0;
            s1_scale       <= '0;
            s1_color       <= '0;
            s1_id          <= '0;
            cull_count_out <= '0;
        end else begin
            s1_valid <= valid_in && front_facing_in;
            s1_scale <= scale[SCALE_W-1:0];
            s1_color <= color_in;
            s1_id    <= tri_id_in;
            if (valid_in && !front_facing_in && (cull_count_out != '1))
                cull_count_out <= cull_count_out + 1'b1;
        end
    end

    // S2: full-width per-channel products.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
            s2_id    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_r     <= {{SCALE_W{1'b0}}, s1_color.r} * {5'b0, s1_scale};
            s2_g     <= {{SCALE_W{1'b0}}, s1_color.g} * {6'b0, s1_scale};
            s2_b     <= {{SCALE_W{1'b0}}, s1_color.b} * {5'b0, s1_scale};
            s2_id    <= s1_id;
        end
    end

    // S3: drop fraction bits (scale <= 1.0 keeps each channel in range) and repack.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s3_valid <= 1'b0;
            s3_color <= '0;
            s3_id    <= '0;
        end else begin
            s3_valid   <= s2_valid;
            s3_color.r <= 5'(s2_r >> NORM_FRAC);
            s3_color.g <= 6'(s2_g >> NORM_FRAC);
            s3_color.b <= 5'(s2_b >> NORM_FRAC);
            s3_id      <= s2_id;
        end
    end

    assign valid_out   = !fifo_empty;
    assign fifo_rd     = valid_out && ready_in;
    assign fifo_accept = s3_valid && (!fifo_full || fifo_rd);
    assign tri_id_out  = fifo_head[PAY_W-1:16];
    assign color_out   = fifo_head[15:0];

    shade_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .wr_en (s3_valid),
        .din   ({s3_id, s3_color}),
        .full  (fifo_full),
        .rd_en (fifo_rd),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .level (fifo_level_out)
    );

    // Count accepted writes and latch overflow when a shaded face is dropped.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shade_count_out <= '0;
            overflow_out    <= 1'b0;
        end else begin
            if (fifo_accept && (shade_count_out != '1))
                shade_count_out <= shade_count_out + 1'b1;
            if (s3_valid && !fifo_accept)
                overflow_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_face_shade_stage.sv
// Scoreboard bench for face_shade_stage: directed faces, monitor pops and compares.
module tb_face_shade_stage;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               valid_in;
    logic               front_facing_in;
    logic signed [15:0] intensity_in;
    logic [15:0]        color_in;
    logic [11:0]        tri_id_in;
    logic               valid_out;
    logic               ready_in;
    logic [15:0]        color_out;
    logic [11:0]        tri_id_out;
    logic [3:0]         fifo_level_out;
    logic               overflow_out;
    logic [15:0]        cull_count_out;
    logic [15:0]        shade_count_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [27:0] sb [$];

    face_shade_stage #(
        .NORM_WIDTH  (16),
        .NORM_FRAC   (14),
        .ID_WIDTH    (12),
        .AMBIENT     (16'h0CCD),
        .FIFO_DEPTH  (8),
        .COUNT_WIDTH (16)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .valid_in        (valid_in),
        .front_facing_in (front_facing_in),
        .intensity_in    (intensity_in),
        .color_in        (color_in),
        .tri_id_in       (tri_id_in),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .color_out       (color_out),
        .tri_id_out      (tri_id_out),
        .fifo_level_out  (fifo_level_out),
        .overflow_out    (overflow_out),
        .cull_count_out  (cull_count_out),
        .shade_count_out (shade_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the scoreboard and compares the head.
    always @(negedge clk_in) begin
        logic [27:0] e;
        if (!rst_in && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got id 0x%0h color 0x%0h expected no output",
                         tri_id_out, color_out);
            end else begin
                e = sb.pop_front();
                check("pop_id", 32'(tri_id_out), 32'(e[27:16]));
                check("pop_color", 32'(color_out), 32'(e[15:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        tick(2);
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic send(input logic ff, input logic [15:0] inten, input logic [15:0] col,
                        input logic [11:0] id, input logic [15:0] exp_col, input logic keep);
        valid_in        = 1'b1;
        front_facing_in = ff;
        intensity_in    = inten;
        color_in        = col;
        tri_id_in       = id;
        if (keep)
            sb.push_back({id, exp_col});
        tick(1);
        valid_in        = 1'b0;
        front_facing_in = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_out), 0);
        check({tag, "_color"}, 32'(color_out), 0);
        check({tag, "_id"}, 32'(tri_id_out), 0);
        check({tag, "_level"}, 32'(fifo_level_out), 0);
        check({tag, "_ovf"}, 32'(overflow_out), 0);
        check({tag, "_cull"}, 32'(cull_count_out), 0);
        check({tag, "_shade"}, 32'(shade_count_out), 0);
    endtask

    initial begin
        rst_in = 1'b1; valid_in = 1'b0; front_facing_in = 1'b0; intensity_in = '0;
        color_in = '0; tri_id_in = '0; ready_in = 1'b0;

        // Reset state
        do_reset();
        check_idle_zero("reset");

        // Half intensity plus ambient, with latency check
        ready_in = 1'b1;
        send(1'b1, 16'h2000, 16'hFFE0, 12'd5, 16'hAD80, 1'b1);
        tick(2);
        check("lat_c3_valid", 32'(valid_out), 0);
        tick(1);
        check("lat_c4_valid", 32'(valid_out), 1);
        check("lat_c4_id", 32'(tri_id_out), 5);
        tick(3);
        check("half_shade_cnt", 32'(shade_count_out), 1);

        // Clamping: negative, above unit, and in-range 0.75
        send(1'b1, 16'hF000, 16'hFFFF, 12'd6, 16'h3186, 1'b1);
        send(1'b1, 16'h4000, 16'hFFFF, 12'd7, 16'hFFFF, 1'b1);
        send(1'b1, 16'h3000, 16'hFFE0, 12'd8, 16'hEF60, 1'b1);
        tick(8);
        check("clamp_drained", 32'(sb.size()), 0);
        check("clamp_shade_cnt", 32'(shade_count_out), 4);

        // Culling
        do_reset();
        ready_in = 1'b1;
        send(1'b1, 16'h2000, 16'hFFE0, 12'd1, 16'hAD80, 1'b1);
        send(1'b0, 16'h2000, 16'hFFE0, 12'd2, 16'hAD80, 1'b0);
        send(1'b0, 16'h2000, 16'hFFE0, 12'd3, 16'hAD80, 1'b0);
        send(1'b1, 16'h2000, 16'hFFE0, 12'd4, 16'hAD80, 1'b1);
        tick(8);
        check("cull_drained", 32'(sb.size()), 0);
        check("cull_count", 32'(cull_count_out), 2);
        check("cull_shade_cnt", 32'(shade_count_out), 2);

        // Backpressure and overflow: ids 8 and 9 are dropped
        do_reset();
        ready_in = 1'b0;
        for (int i = 0; i < 10; i++)
            send(1'b1, 16'h4000, 16'h1000 + 16'(i), 12'(i), 16'h1000 + 16'(i), i < 8);
        tick(6);
        check("ovf_level", 32'(fifo_level_out), 8);
        check("ovf_flag", 32'(overflow_out), 1);
        check("ovf_shade_cnt", 32'(shade_count_out), 8);
        check("hold_id_a", 32'(tri_id_out), 0);
        check("hold_color_a", 32'(color_out), 32'h1000);
        tick(3);
        check("hold_id_b", 32'(tri_id_out), 0);
        check("hold_color_b", 32'(color_out), 32'h1000);
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            check("drain_valid", 32'(valid_out), 1);
        end
        @(negedge clk_in);
        check("drain_end_valid", 32'(valid_out), 0);
        check("drain_sb_empty", 32'(sb.size()), 0);
        check("ovf_sticky", 32'(overflow_out), 1);
        tick(1);

        // Full FIFO with a same-cycle pop: face 8 is accepted and comes out last
        do_reset();
        ready_in = 1'b0;
        for (int i = 0; i < 9; i++)
            send(1'b1, 16'h4000, 16'h2000 + 16'(i), 12'(i), 16'h2000 + 16'(i), 1'b1);
        tick(2);
        check("fullpop_pre_level", 32'(fifo_level_out), 8);
        ready_in = 1'b1;
        tick(1);
        ready_in = 1'b0;
        check("fullpop_level", 32'(fifo_level_out), 8);
        check("fullpop_ovf", 32'(overflow_out), 0);
        tick(3);
        check("fullpop_shade_cnt", 32'(shade_count_out), 9);
        ready_in = 1'b1;
        tick(12);
        check("fullpop_drained", 32'(sb.size()), 0);
        check("fullpop_end_level", 32'(fifo_level_out), 0);

        // Reset mid-burst: 5 queued, 3 in flight, input present during reset
        do_reset();
        ready_in = 1'b0;
        for (int i = 0; i < 8; i++)
            send(1'b1, 16'h4000, 16'h3000 + 16'(i), 12'(i), 16'h3000 + 16'(i), 1'b1);
        check("midrst_pre_level", 32'(fifo_level_out), 5);
        rst_in          = 1'b1;
        valid_in        = 1'b1;
        front_facing_in = 1'b1;
        tri_id_in       = 12'd9;
        ready_in        = 1'b1;
        tick(1);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        sb.delete();
        check_idle_zero("midrst");
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("midrst_no_stale", 32'(valid_out), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
